// File: rtl/sw_debounce.sv
// Switch input conditioner.
// Each raw switch bit is brought into the clk domain through a plain
// flip-flop chain and then debounced by its own stability counter. The
// debounced level sw_clean only follows the synchronised level once that
// level has differed from it for CNT_MAX consecutive cycles. Registered
// per-bit rise/fall strobes and an any-change strobe accompany every update.
module sw_debounce #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_MAX     = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed
);

  // Counter only has to hold 0 .. CNT_MAX-1, but keep at least one bit.
  localparam int CNT_W = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [WIDTH-1:0] s;

  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic [WIDTH-1:0] clean_nxt;
  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] fall_nxt;

  // One step of a stability counter. The caller guarantees the counter is
  // below CNT_LAST, so the increment can never wrap.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c);
    return c + CNT_W'(1);
  endfunction

  // Synchroniser chain: pure flop-to-flop, no logic between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_p[k] <= '0;
      end
    end else begin
      sync_p[0] <= sw_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_p[k] <= sync_p[k-1];
      end
    end
  end

  assign s = sync_p[SYNC_STAGES-1];

  // Per-bit debounce decision: restart the window whenever the synchronised
  // level agrees with sw_clean, accept the new level on the last count.
  always_comb begin
    cnt_nxt   = cnt;
    clean_nxt = sw_clean;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == sw_clean[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        clean_nxt[i] = s[i];
        cnt_nxt[i]   = '0;
      end else begin
        cnt_nxt[i] = cnt_step(cnt[i]);
      end
    end
    rise_nxt = clean_nxt & ~sw_clean;
    fall_nxt = ~clean_nxt & sw_clean;
  end

  // Counters, debounced level and strobes all update on the same edge so the
  // strobes line up with the first cycle sw_clean shows its new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
      sw_clean <= '0;
      sw_rise  <= '0;
      sw_fall  <= '0;
      changed  <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      sw_clean <= clean_nxt;
      sw_rise  <= rise_nxt;
      sw_fall  <= fall_nxt;
      changed  <= |(rise_nxt | fall_nxt);
    end
  end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input-conditioning stage between the board slide switches and the switch-driven logic (stair light, half adder, 2-bit ripple adder).
- Synchronises each raw switch into the clock domain and debounces it with a per-bit stability counter.
- Presents a clean switch bus plus per-bit rise/fall strobes and an any-change strobe.
- Consumers connect sw_clean in place of the raw switch bus; strobes are for future sequential consumers.

Parameters:
- WIDTH, 8, number of switch bits conditioned.
- SYNC_STAGES, 2, flip-flops in each synchroniser chain; legal values are 2 or more.
- CNT_MAX, 1000000, consecutive cycles a synchronised bit must differ from sw_clean before sw_clean follows it (10 ms at 100 MHz); legal values are 1 or more.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sw_raw  input  WIDTH  raw, asynchronous, bouncing switch levels.
- sw_clean  output  WIDTH  debounced, registered switch levels.
- sw_rise  output  WIDTH  per-bit one-cycle strobe; sw_clean[i] just went 0->1.
- sw_fall  output  WIDTH  per-bit one-cycle strobe; sw_clean[i] just went 1->0.
- changed  output  1  one-cycle strobe; OR of sw_rise and sw_fall.

Behaviour:
- Reset is asynchronous and active-low:
  - rst_n low immediately clears all synchroniser flops, counters, sw_clean, sw_rise, sw_fall and changed to 0.
  - Release is synchronous in effect: the first state update happens on the first rising clk edge with rst_n high.
- Synchroniser:
  - sw_raw[i] passes through SYNC_STAGES flops; the last stage is s[i].
  - There is no logic between stages.
  - s is internal and is the only signal the debounce logic reads.
- Per-bit counter cnt[i]:
  - Width is $clog2(CNT_MAX+1), minimum 1.
  - Bits are fully independent; there is no shared counter.
- Each rising edge, for each bit i:
  - If s[i] == sw_clean[i]: cnt[i] <= 0; sw_clean[i] holds.
  - Else if cnt[i] == CNT_MAX-1: sw_clean[i] <= s[i]; cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- Strobes:
  - sw_rise[i] and sw_fall[i] are registered on the same edge that updates sw_clean[i].
  - They are high for exactly the one cycle in which sw_clean[i] first shows its new value, then low.
  - changed is registered on the same edge, equal to the OR of the next sw_rise and sw_fall vectors.
  - All outputs are registered; there are no combinational paths from sw_raw to any output.
- Latency:
  - A clean level change on sw_raw, stable for at least the setup window, appears on sw_clean after exactly SYNC_STAGES+CNT_MAX rising edges.
  - The edge that first samples the new level counts as edge 1.
  - Defaults: 2+1000000 edges. With CNT_MAX=4: 6 edges.
- Glitch rejection:
  - If s[i] returns to sw_clean[i] before the count completes, cnt[i] clears and sw_clean[i] never changes.
  - A bounce mid-count restarts the full CNT_MAX window.
- Counter bound: cnt[i] never exceeds CNT_MAX-1; there is no wrap-around.
- CNT_MAX=1: sw_clean follows s with one edge of delay; single-cycle glitches in s still propagate.
- Simultaneous events:
  - Any number of bits may qualify on the same edge; each sets its own strobe.
  - changed is a single pulse regardless of how many bits toggled.
- Reset mid-count: the count is discarded and sw_clean returns to 0.
- Switch held high through reset: after release, sw_clean rises SYNC_STAGES+CNT_MAX edges later and sw_rise pulses once. This is required behaviour, not a fault.
- Static state: while sw_raw is constant and equals sw_clean, counters stay at 0 and all strobes stay low.

Test Plan (CNT_MAX=4, SYNC_STAGES=2, WIDTH=8 unless stated):
- Reset, then sw_raw=8'h00 held for 20 cycles -> sw_clean=8'h00; sw_rise, sw_fall and changed never asserted; rst_n low mid-run forces all outputs 0 asynchronously, before the next clk edge.
- sw_raw steps 8'h00->8'h05 just before edge 1 -> sw_clean=8'h05 visible after edge 6, not earlier; sw_rise=8'h05 and changed=1 for exactly that one cycle.
- Bit 3 bounce: raw 1 for 2 cycles, 0 for 1, then 1 held -> sw_clean[3] rises only after 4 consecutive high synchronised samples, measured from the last bounce; exactly one sw_rise[3] pulse.
- Glitch: sw_raw[7] high for 3 cycles, then low -> sw_clean[7] stays 0; no strobes.
- Simultaneous: sw_clean=8'hF0, raw->8'h0F -> on a single edge sw_clean=8'h0F, sw_rise=8'h0F, sw_fall=8'hF0, changed high for one cycle only.
- Reset with sw_raw=8'hFF held -> sw_clean=8'h00 during reset; 6 edges after release sw_clean=8'hFF with one sw_rise=8'hFF pulse. Repeat with CNT_MAX=1 -> update after 3 edges.
